buf_seq_ctrl: RTL and testbench
===============================

# buf_seq_ctrl

Sequencer for a single-port frame buffer RAM addressed by a 9-bit address-tracking counter. On `start`, it runs two phases. The fill phase writes FRAME_LEN words from a producer using a valid/ready handshake. The drain phase then reads the same FRAME_LEN words back to a consumer. The block owns the RAM write-enable and address, and enables the address counter only on accepted transfers, so the producer and consumer never contend for the RAM.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 7: RAM address width.
- CNT_WIDTH, RAM_ADDR_WIDTH+2 (=9): internal address counter width.
- FRAME_LEN, 128: words per frame. Legal range is 1..2^RAM_ADDR_WIDTH.

Ports:
- clk  in  1  clock. All state updates on its rising edge.
- asyn_reset  in  1  reset. Asynchronous, active-high.
- start  in  1  begin one frame. Sampled only in IDLE.
- wr_valid  in  1  producer word available.
- wr_ready  out  1  buffer accepts the producer word.
- rd_ready  in  1  consumer can take a word.
- rd_valid  out  1  RAM read data valid for the consumer.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_ADDR_WIDTH  RAM address, equal to cnt[RAM_ADDR_WIDTH-1:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when a frame completes.
- frame_cnt  out  8  completed-frame count. Wraps 255 to 0.

## Operation
The state machine has five states: IDLE, FILL, TURN, DRAIN, DONE.

- **IDLE**: cnt held at 0. wr_ready=0 and ram_we=0. If start=1, go to FILL.
- **FILL**:
  - wr_ready=1.
  - A write fires when wr_valid&&wr_ready. On that cycle ram_we=1, ram_addr=cnt, and cnt increments.
  - After the write at cnt==FRAME_LEN-1: cnt clears to 0 and the state goes to TURN.
- **TURN**: one bubble cycle with no RAM access and cnt=0. Next state is DRAIN.
- **DRAIN**:
  - A read issues when rd_ready=1. On that cycle ram_we=0, ram_addr=cnt, and cnt increments.
  - rd_valid goes high the cycle after each issued read, for one cycle, matching RAM read latency 1.
  - The consumer must accept every word while rd_valid=1.
  - After the read at cnt==FRAME_LEN-1: cnt clears and the state goes to DONE.
- **DONE**:
  - rd_valid=1 for the final word.
  - done=1 and frame_cnt increments.
  - Next state is IDLE.

Counter and comparison rules:
- cnt is CNT_WIDTH bits wide, and only the low RAM_ADDR_WIDTH bits drive ram_addr.
- The comparison uses the full CNT_WIDTH, so a FRAME_LEN of exactly 2^RAM_ADDR_WIDTH terminates correctly.

Boundary conditions:
- start outside IDLE is ignored. It is not queued.
- start held high through DONE starts a new frame on the first IDLE cycle. Minimum gap is DONE → IDLE → FILL.
- wr_valid=0 in FILL stalls with cnt held, for any number of cycles.
- rd_ready=0 in DRAIN stalls with cnt held. rd_valid for a previously issued read still asserts.
- wr_valid in any state other than FILL is ignored, and wr_ready=0.
- FRAME_LEN=1: FILL and DRAIN each last one accepted transfer.

Reset values:
- asyn_reset at any time, including mid-frame, immediately forces the following. The partial frame is discarded.
  - state=IDLE, cnt=0, frame_cnt=0.
  - wr_ready=0, rd_valid=0, ram_we=0, ram_addr=0, busy=0, done=0.

## Timing
- wr_ready, ram_we, ram_addr and busy are decoded from registered state and cnt, with a combinational dependence on wr_valid/rd_ready for ram_we.
- rd_valid and done are registered.
- Latency from start to first write opportunity: 1 cycle (the FILL state).
- Last write to first read issue: 2 cycles, because of TURN.
- Last read issue to done pulse: 1 cycle.
- Minimum frame duration with no stalls: 2·FRAME_LEN + 3 cycles, from start sampled to done.

## Structure
- Shared package `buf_seq_pkg` holds:
  - the state enum, encoded IDLE=0, FILL=1, TURN=2, DRAIN=3, DONE=4, 3 bits;
  - the default constants RAM_ADDR_WIDTH and FRAME_LEN.
- One sub-module, `seq_addr_cnt`: a CNT_WIDTH counter with async reset, synchronous clear and enable.
- Next-state logic, handshake decode and the frame counter live in the top module.

## Test plan
- **Reset mid-FILL**: start, write 5 words, then pulse asyn_reset. Expect cnt=0, busy=0, wr_ready=0 and frame_cnt=0 immediately. A subsequent start rewrites from address 0.
- **Full frame, FRAME_LEN=128, no stalls**:
  - ram_we high on 128 consecutive cycles with addresses 0..127, then one TURN cycle.
  - Reads issued on addresses 0..127, with rd_valid lagging by 1.
  - done pulses at cycle 259 after start, and frame_cnt=1.
- **Random stalls**: wr_valid and rd_ready toggled at 50%. Expect no address skipped or repeated, and data read equals data written in order.
- **start in a non-IDLE state**: start during FILL, DRAIN and DONE is ignored. Start held high continuously gives back-to-back frames with a 1-cycle IDLE gap.
- **FRAME_LEN=1**: expect one write at address 0, TURN, one read at address 0, then done.
- **frame_cnt wrap**: run 256 frames of FRAME_LEN=2. Expect frame_cnt to wrap to 0 with done still pulsing.

Source files
------------

// File: rtl/buf_seq_pkg.sv
// Shared types and default sizing for the frame buffer sequencer.
package buf_seq_pkg;

    localparam int RAM_ADDR_WIDTH_DEF = 7;
    localparam int FRAME_LEN_DEF      = 128;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        TURN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_addr_cnt.sv
// Address-tracking counter: async reset, synchronous clear (wins over enable), count enable.
module seq_addr_cnt
    import buf_seq_pkg::*;
#(
    parameter int CNT_WIDTH = RAM_ADDR_WIDTH_DEF + 2
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/buf_seq_ctrl.sv
// Frame buffer sequencer: fills FRAME_LEN words from a producer, then drains them
// to a consumer, owning the single-port RAM write enable and address.
module buf_seq_ctrl
    import buf_seq_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = RAM_ADDR_WIDTH + 2,
    parameter int FRAME_LEN      = FRAME_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      asyn_reset,
    input  logic                      start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                frame_cnt
);

    // Full-width compare so FRAME_LEN == 2**RAM_ADDR_WIDTH still terminates.
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_clr;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 last;

    assign last     = (cnt == LAST_IDX);
    assign ram_addr = cnt[RAM_ADDR_WIDTH-1:0];

    seq_addr_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_addr_cnt (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .clr        (cnt_clr),
        .en         (wr_fire | rd_fire),
        .cnt        (cnt)
    );

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        wr_fire   = 1'b0;
        rd_fire   = 1'b0;
        cnt_clr   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                cnt_clr = 1'b1;
                if (start) state_nxt = FILL;
            end
            FILL: begin
                wr_ready = 1'b1;
                wr_fire  = wr_valid;
                ram_we   = wr_valid;
                if (wr_valid && last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = TURN;
                end
            end
            TURN: begin
                cnt_clr   = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                rd_fire = rd_ready;
                if (rd_ready && last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // rd_valid follows the RAM's one-cycle read latency; done marks the DONE cycle.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rd_fire;
            done     <= rd_fire && last;
            if (rd_fire && last) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_buf_seq_ctrl.sv
// Self-checking bench for buf_seq_ctrl: per-cycle reference model plus RAM model,
// a vector table for FRAME_LEN=1, and directed multi-cycle sequences.
module tb_buf_seq_ctrl;

    localparam int AW = 7;

    logic clk = 1'b0;
    logic asyn_reset, start, wr_valid, rd_ready;
    logic [15:0] wdata;

    logic          wr_ready_o [3];
    logic          rd_valid_o [3];
    logic          ram_we_o   [3];
    logic          busy_o     [3];
    logic          done_o     [3];
    logic [AW-1:0] ram_addr_o [3];
    logic [7:0]    frame_cnt_o[3];

    logic [1:0] sel;
    int         lens [3] = '{128, 1, 2};

    logic          m_wr_ready, m_rd_valid, m_ram_we, m_busy, m_done;
    logic [AW-1:0] m_ram_addr;
    logic [7:0]    m_frame_cnt;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    buf_seq_ctrl #(.RAM_ADDR_WIDTH(AW), .FRAME_LEN(128)) dut_a (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .wr_valid(wr_valid),
        .wr_ready(wr_ready_o[0]), .rd_ready(rd_ready), .rd_valid(rd_valid_o[0]),
        .ram_we(ram_we_o[0]), .ram_addr(ram_addr_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .frame_cnt(frame_cnt_o[0]));

    buf_seq_ctrl #(.RAM_ADDR_WIDTH(AW), .FRAME_LEN(1)) dut_b (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .wr_valid(wr_valid),
        .wr_ready(wr_ready_o[1]), .rd_ready(rd_ready), .rd_valid(rd_valid_o[1]),
        .ram_we(ram_we_o[1]), .ram_addr(ram_addr_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .frame_cnt(frame_cnt_o[1]));

    buf_seq_ctrl #(.RAM_ADDR_WIDTH(AW), .FRAME_LEN(2)) dut_c (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .wr_valid(wr_valid),
        .wr_ready(wr_ready_o[2]), .rd_ready(rd_ready), .rd_valid(rd_valid_o[2]),
        .ram_we(ram_we_o[2]), .ram_addr(ram_addr_o[2]), .busy(busy_o[2]),
        .done(done_o[2]), .frame_cnt(frame_cnt_o[2]));

    always_comb begin
        m_wr_ready  = wr_ready_o[sel];
        m_rd_valid  = rd_valid_o[sel];
        m_ram_we    = ram_we_o[sel];
        m_busy      = busy_o[sel];
        m_done      = done_o[sel];
        m_ram_addr  = ram_addr_o[sel];
        m_frame_cnt = frame_cnt_o[sel];
    end

    // Single-port RAM with one-cycle read latency, driven by the selected DUT.
    logic [15:0] mem [128];
    logic [15:0] rdata;
    always @(posedge clk) begin
        if (m_ram_we) mem[m_ram_addr] <= wdata;
        rdata <= mem[m_ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        nchk++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    // Reference model: counts of accepted writes/issued reads within the active frame.
    bit          act, turn_seen, rv_exp;
    int          nw, nr, fc_exp;
    logic [15:0] dq[$];

    always @(negedge clk) begin
        int  n, ad;
        bit  wrr, we, rdi, dn;
        if (asyn_reset) begin
            check("rst_wr_ready",  m_wr_ready,  0);
            check("rst_ram_we",    m_ram_we,    0);
            check("rst_ram_addr",  m_ram_addr,  0);
            check("rst_busy",      m_busy,      0);
            check("rst_rd_valid",  m_rd_valid,  0);
            check("rst_done",      m_done,      0);
            check("rst_frame_cnt", m_frame_cnt, 0);
            act = 0; turn_seen = 0; rv_exp = 0; nw = 0; nr = 0; fc_exp = 0;
            dq.delete();
        end else begin
            n   = lens[sel];
            wrr = act && (nw < n);
            we  = wrr && wr_valid;
            ad  = (nw < n) ? nw : ((nr < n) ? nr : 0);
            rdi = act && (nw == n) && turn_seen && (nr < n) && rd_ready;
            dn  = act && (nr == n);
            check("wr_ready", m_wr_ready, wrr);
            check("ram_we",   m_ram_we,   we);
            check("ram_addr", m_ram_addr, ad % 128);
            check("busy",     m_busy,     act);
            check("rd_valid", m_rd_valid, rv_exp);
            check("done",     m_done,     dn);
            if (!dn) check("frame_cnt", m_frame_cnt, fc_exp);
            if (rv_exp && dq.size() > 0) check("rd_data", rdata, dq.pop_front());
            if (we) dq.push_back(wdata);
            rv_exp = rdi;
            if (!act) begin
                if (start) begin
                    act = 1; nw = 0; nr = 0; turn_seen = 0;
                end
            end else if (dn) begin
                act = 0; nw = 0; nr = 0; turn_seen = 0;
                fc_exp = (fc_exp + 1) % 256;
            end else begin
                if (we) nw++;
                else if (nw == n && !turn_seen) turn_seen = 1;
                if (rdi) nr++;
            end
        end
    end

    // mode 0: inputs held; 1: random wr_valid/rd_ready; 2: as 1 plus random start.
    task automatic run_frame(input int mode, input int maxc, output int cyc,
                             output int nwe, output int first_we, output int last_we);
        cyc = 1; nwe = 0; first_we = 0; last_we = 0;
        @(negedge clk);
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            wdata = 16'($urandom);
            start = (mode == 2) ? 1'($urandom % 2) : 1'b0;
            if (mode >= 1) begin
                wr_valid = 1'($urandom % 2);
                rd_ready = 1'($urandom % 2);
            end
            cyc++;
            @(negedge clk);
            if (m_ram_we) begin
                nwe++;
                if (first_we == 0) first_we = cyc;
                last_we = cyc;
            end
            if (m_done) return;
        end
        check("done_within_bound", m_done, 1);
    endtask

    task automatic step();
        @(posedge clk); #1;
        wdata = 16'($urandom);
    endtask

    typedef struct {
        bit st, wv, rr;
        bit wrr, we;
        int addr;
        bit bsy, rv, dn;
        int fc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int cyc, nwe, fwe, lwe, nd, c1, c2;
        asyn_reset = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wdata = 16'h0; sel = 2'd0;

        tbl[0] = '{0,0,0, 0,0,0, 0,0,0,  0};
        tbl[1] = '{1,1,0, 0,0,0, 0,0,0,  0};
        tbl[2] = '{1,0,0, 1,0,0, 1,0,0,  0};
        tbl[3] = '{1,1,0, 1,1,0, 1,0,0,  0};
        tbl[4] = '{0,1,1, 0,0,0, 1,0,0,  0};
        tbl[5] = '{0,0,0, 0,0,0, 1,0,0,  0};
        tbl[6] = '{1,0,1, 0,0,0, 1,0,0,  0};
        tbl[7] = '{1,1,1, 0,0,0, 1,1,1, -1};
        tbl[8] = '{0,1,1, 0,0,0, 0,0,0,  1};
        tbl[9] = '{0,0,0, 0,0,0, 0,0,0,  1};

        repeat (3) @(posedge clk);
        #1 asyn_reset = 1'b0;
        step();

        // Full frame, no stalls, FRAME_LEN=128.
        start = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
        run_frame(0, 400, cyc, nwe, fwe, lwe);
        check("full_done_cycle", cyc, 2 * 128 + 3);
        check("full_we_count", nwe, 128);
        check("full_we_span", lwe - fwe + 1, 128);
        step();
        @(negedge clk);
        check("full_frame_cnt", m_frame_cnt, 1);
        check("full_idle_busy", m_busy, 0);

        // Reset in the middle of FILL after 5 writes.
        step(); start = 1'b1;
        step(); start = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("midfill_addr", m_ram_addr, 5);
        @(posedge clk); #1 asyn_reset = 1'b1;
        #1;
        check("midfill_rst_busy", m_busy, 0);
        check("midfill_rst_wr_ready", m_wr_ready, 0);
        check("midfill_rst_addr", m_ram_addr, 0);
        check("midfill_rst_frame_cnt", m_frame_cnt, 0);
        step(); asyn_reset = 1'b0;
        step();
        start = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
        run_frame(0, 400, cyc, nwe, fwe, lwe);
        check("refill_we_count", nwe, 128);
        step(); start = 1'b0;

        // Random stalls and stray start pulses.
        for (int f = 0; f < 2; f++) begin
            step(); start = 1'b1;
            run_frame(2, 3000, cyc, nwe, fwe, lwe);
            check("rand_we_count", nwe, 128);
            step(); start = 1'b0;
            step();
            @(negedge clk);
            check("rand_queue_empty", dq.size(), 0);
            check("rand_frame_cnt", m_frame_cnt, f + 2);
        end

        // FRAME_LEN=1 vector table.
        @(posedge clk); #1 asyn_reset = 1'b1; sel = 2'd1;
        step(); asyn_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st; wr_valid = tbl[i].wv; rd_ready = tbl[i].rr;
            @(negedge clk);
            check($sformatf("tbl%0d_wr_ready", i), m_wr_ready, tbl[i].wrr);
            check($sformatf("tbl%0d_ram_we", i),   m_ram_we,   tbl[i].we);
            check($sformatf("tbl%0d_ram_addr", i), m_ram_addr, tbl[i].addr);
            check($sformatf("tbl%0d_busy", i),     m_busy,     tbl[i].bsy);
            check($sformatf("tbl%0d_rd_valid", i), m_rd_valid, tbl[i].rv);
            check($sformatf("tbl%0d_done", i),     m_done,     tbl[i].dn);
            if (tbl[i].fc >= 0) check($sformatf("tbl%0d_frame_cnt", i), m_frame_cnt, tbl[i].fc);
            step();
        end

        // FRAME_LEN=2, start held: back-to-back frames and frame_cnt wrap.
        @(posedge clk); #1 asyn_reset = 1'b1; sel = 2'd2;
        step(); asyn_reset = 1'b0;
        start = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1;
        nd = 0; c1 = 0; c2 = 0; cyc = 0;
        for (int i = 0; i < 3000 && nd < 256; i++) begin
            step();
            cyc++;
            @(negedge clk);
            if (m_done) begin
                nd++;
                if (nd == 1) c1 = cyc;
                if (nd == 2) c2 = cyc;
            end
        end
        start = 1'b0;
        check("wrap_done_count", nd, 256);
        check("b2b_interval", c2 - c1, 2 * 2 + 3);
        step();
        @(negedge clk);
        check("wrap_frame_cnt", m_frame_cnt, 0);
        check("wrap_idle_busy", m_busy, 0);
        step();
        @(negedge clk);
        check("wrap_no_restart", m_busy, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
